// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants, the IF/ID record
// and the target arithmetic used by the next-PC selector.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [1:0] {
      SEL_SEQ  = 2'd0,
      SEL_BR   = 2'd1,
      SEL_JUMP = 2'd2,
      SEL_JR   = 2'd3
   } pc_sel_e;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } ifid_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   // Branch offsets count words relative to the instruction after the branch.
   function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                 input logic [15:0] imm);
      return pc_plus4 + (sign_ext16(imm) << 2);
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] addr);
      return {pc_plus4[31:28], addr, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's decode-side redirect controls, ROM link and IF/ID outputs.
interface fetch_unit_if;

   logic        stall;
   logic        br_taken;
   logic [15:0] br_imm;
   logic        jump;
   logic [25:0] jump_addr;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] ins_in;
   logic [31:0] ins_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        valid_out;
   logic        fault;

   modport master (
      input  stall, br_taken, br_imm, jump, jump_addr, jr, jr_target, ins_in,
      output pc, ins_out, pc_out, pc_plus4, valid_out, fault
   );

   modport slave (
      output stall, br_taken, br_imm, jump, jump_addr, jr, jr_target, ins_in,
      input  pc, ins_out, pc_out, pc_plus4, valid_out, fault
   );

endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Next-PC selection: sequential flow or a decode redirect with priority jr > jump > branch.
module next_pc_mux
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_plus4,
   input  logic        accept,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   input  logic        jump,
   input  logic [25:0] jump_addr,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        redirect
);

   pc_sel_e sel;

   always_comb begin
      // NOTE: assigning a default before any branch keeps this combinational; a missed path would infer a latch.
      sel = SEL_SEQ;
      if (accept) begin
         if (jr)            sel = SEL_JR;
         else if (jump)     sel = SEL_JUMP;
         else if (br_taken) sel = SEL_BR;
      end
   end

   always_comb begin
      next_pc = pc + 32'd4;
      case (sel)
         SEL_JR:   next_pc = jr_target;
         SEL_JUMP: next_pc = jump_target(pc_plus4, jump_addr);
         SEL_BR:   next_pc = branch_target(pc_plus4, br_imm);
         default:  next_pc = pc + 32'd4;
      endcase
   end

   assign redirect = (sel != SEL_SEQ);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and sticky fetch-fault detection.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_WORDS = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   fetch_unit_if.master bus
);

   localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

   logic [31:0] pc;
   ifid_t       ifid;
   logic        valid;
   logic        fault;
   logic [31:0] next_pc;
   logic        redirect;
   logic        pc_bad;

   // Redirects come from the instruction held in IF/ID, so they only count while it is live.
   next_pc_mux u_next_pc_mux (
      .pc        (pc),
      .pc_plus4  (ifid.pc_plus4),
      .accept    (valid && !bus.stall),
      .br_taken  (bus.br_taken),
      .br_imm    (bus.br_imm),
      .jump      (bus.jump),
      .jump_addr (bus.jump_addr),
      .jr        (bus.jr),
      .jr_target (bus.jr_target),
      .next_pc   (next_pc),
      .redirect  (redirect)
   );

   assign pc_bad = (pc[1:0] != 2'b00) || ({1'b0, pc} >= PC_LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc    <= RESET_PC;
         ifid  <= '0;
         valid <= 1'b0;
         fault <= 1'b0;
      end else if (!bus.stall) begin
         if (fault || pc_bad) begin
            fault <= 1'b1;
            valid <= 1'b0;
         end else if (redirect) begin
            pc    <= next_pc;
            valid <= 1'b0;
         end else begin
            pc    <= next_pc;
            ifid  <= '{ins: bus.ins_in, pc: pc, pc_plus4: pc + 32'd4};
            valid <= 1'b1;
         end
      end
   end

   assign bus.pc        = pc;
   assign bus.ins_out   = ifid.ins;
   assign bus.pc_out    = ifid.pc;
   assign bus.pc_plus4  = ifid.pc_plus4;
   assign bus.valid_out = valid;
   assign bus.fault     = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC model and an IF/ID scoreboard queue.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int unsigned IMEM_WORDS = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rom [IMEM_WORDS];
   logic [31:0] m_pc;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_fault;
   ifid_t       exp_q [$];

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.ins_in = rom[bus.pc[6:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.stall     = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_imm    = 16'h0;
      bus.jump      = 1'b0;
      bus.jump_addr = 26'h0;
      bus.jr        = 1'b0;
      bus.jr_target = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_pc", bus.pc, 32'h0);
      check("rst_valid", bus.valid_out, 32'h0);
      check("rst_fault", bus.fault, 32'h0);
      check("rst_ins", bus.ins_out, 32'h0);
      check("rst_pc_out", bus.pc_out, 32'h0);
      check("rst_pc4", bus.pc_plus4, 32'h0);
      m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Predict the edge from the current inputs, clock once, then compare.
   task automatic step();
      logic  capture;
      ifid_t want;
      capture = 1'b0;
      if (!bus.stall) begin
         if (m_fault || m_pc[1:0] != 2'b00 || m_pc >= IMEM_WORDS * 4) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
         end else if (m_valid && (bus.jr || bus.jump || bus.br_taken)) begin
            if (bus.jr)        m_pc = bus.jr_target;
            else if (bus.jump) m_pc = {m_pc4[31:28], bus.jump_addr, 2'b00};
            else               m_pc = m_pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
            m_valid = 1'b0;
         end else begin
            exp_q.push_back('{ins: rom[m_pc[6:2]], pc: m_pc, pc_plus4: m_pc + 32'd4});
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            capture = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("pc", bus.pc, m_pc);
      check("valid", bus.valid_out, m_valid);
      check("fault", bus.fault, m_fault);
      if (capture) begin
         want = exp_q.pop_front();
         check("ins_out", bus.ins_out, want.ins);
         check("pc_out", bus.pc_out, want.pc);
         check("pc_plus4", bus.pc_plus4, want.pc_plus4);
      end
   endtask

   task automatic run_to(input logic [31:0] target);
      for (int i = 0; i < 20 && !(bus.valid_out === 1'b1 && bus.pc_out === target); i++) step();
      check("run_to", bus.pc_out, target);
   endtask

   initial begin
      for (int i = 0; i < IMEM_WORDS; i++) rom[i] = {6'h08, 5'(i), 5'(i), 16'(i * 3)};
      rom[3]  = {OP_JAL, 26'h18};
      rom[5]  = {OP_J, 26'h0};
      rom[10] = {OP_BEQ, 5'd1, 5'd2, 16'h0004};
      rom[29] = {OP_BNE, 5'd1, 5'd2, 16'hFFFB};
      rom[30] = {OP_RTYPE, 5'd31, 15'd0, FN_JR};
      idle();
      rst_n = 1'b1;
      #2;
      do_reset();

      // Sequential flow from reset
      step(); check("t1_pc4", bus.pc, 32'h4);
      step(); check("t1_pc8", bus.pc, 32'h8);
      step(); check("t1_pcC", bus.pc, 32'hC);
      step(); check("t1_jal_ins", bus.ins_out, 32'h0c00_0018);

      // jal at 0x0C
      bus.jump = 1'b1; bus.jump_addr = 26'h18;
      step();
      check("t2_pc", bus.pc, 32'h60);
      check("t2_bubble", bus.valid_out, 32'h0);
      check("t2_link", bus.pc_plus4, 32'h10);
      idle();
      step(); check("t2_target_pc_out", bus.pc_out, 32'h60);

      // bne at 0x74, taken then not taken
      run_to(32'h74);
      bus.br_taken = 1'b1; bus.br_imm = 16'hFFFB;
      step(); check("t3_taken_pc", bus.pc, 32'h64);
      idle();
      run_to(32'h74);
      step(); check("t3_not_taken_pc", bus.pc, 32'h7C);

      // jr and jump together
      bus.jr = 1'b1; bus.jr_target = 32'h10; bus.jump = 1'b1; bus.jump_addr = 26'h3;
      step(); check("t4_jr_wins", bus.pc, 32'h10);
      idle();
      step();

      // Stall beats a pending branch
      bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_imm = 16'h0002;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_hold_pc", bus.pc, 32'h14);
         check("t5_hold_pc_out", bus.pc_out, 32'h10);
      end
      bus.stall = 1'b0;
      step(); check("t5_redirect", bus.pc, 32'h1C);
      step(); check("t5_once", bus.pc, 32'h20);
      idle();

      // Misaligned jr target faults and freezes fetch
      bus.jr = 1'b1; bus.jr_target = 32'h82;
      step(); check("t6_pc82", bus.pc, 32'h82);
      idle();
      step(); check("t6_fault", bus.fault, 32'h1);
      bus.jr = 1'b1; bus.jr_target = 32'h10;
      step(); check("t6_frozen", bus.pc, 32'h82);
      idle();
      #2;
      do_reset();

      // One past the last ROM word
      step(); step(); step();
      bus.jr = 1'b1; bus.jr_target = 32'h80;
      step(); check("t6_pc80", bus.pc, 32'h80);
      idle();
      step(); check("t6_range_fault", bus.fault, 32'h1);
      check("t6_range_valid", bus.valid_out, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
